despachador_llamadas: RTL and testbench

- Call dispatcher for the two-elevator system.
- Latches floor-call buttons and assigns each pending call to one elevator. Delivers the assignment to the elevator as a destination over a valid/ack handshake, then waits until that elevator reports arrival (floor match with doors open).
- Sits between the switch/button inputs and the two elevator cores. It consumes their piso/direccion/puertas_abiertas status and produces their destino commands.

---
 rtl/despachador_llamadas_pkg.sv | 19 +
 rtl/despachador_llamadas_asignador_asc.sv | 108 ++++++++++
 rtl/despachador_llamadas.sv | 139 +++++++++++++
 tb/tb_despachador_llamadas.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/despachador_llamadas_pkg.sv
// Shared definitions for the two-elevator call dispatcher: per-elevator
// FSM state encoding, elevator direction codes and default sizing.
package despacho_pkg;

  localparam int N_PISOS_DEF        = 4;
  localparam int PISO_W_DEF         = 2;
  localparam int TIMEOUT_CICLOS_DEF = 1024;

  typedef enum logic [1:0] {
    LIBRE     = 2'd0,
    ASIGNANDO = 2'd1,
    EN_VIAJE  = 2'd2
  } estado_t;

  localparam logic [1:0] DIR_PARADO = 2'b00;
  localparam logic [1:0] DIR_SUBE   = 2'b01;
  localparam logic [1:0] DIR_BAJA   = 2'b10;

endpackage

// File: rtl/despachador_llamadas_asignador_asc.sv
// Per-elevator assignment engine: FSM LIBRE -> ASIGNANDO -> EN_VIAJE,
// destino/valid registers, arrival detection and, with the macro
// DESPACHO_TIMEOUT_EN defined, an ack timeout that releases the call.
//
// Handshake: o_valido rises with o_destino loaded and both stay constant
// until i_ack is sampled high on a clock edge; that edge completes the
// transfer and o_valido is low from the next cycle. i_ack is ignored while
// o_valido is low.
module asignador_asc
  import despacho_pkg::*;
#(
  parameter int PISO_W         = PISO_W_DEF,
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_asignar,
  input  logic [PISO_W-1:0] i_destino,
  input  logic [PISO_W-1:0] i_piso,
  input  logic [1:0]        i_direccion,
  input  logic              i_puertas,
  input  logic              i_ack,
  output logic [PISO_W-1:0] o_destino,
  output logic              o_valido,
  output logic              o_elegible,
  output logic              o_llegada,
  output logic              o_timeout,
  output logic [1:0]        o_estado
);

  estado_t           r_estado;
  estado_t           w_estado_sig;
  logic [PISO_W-1:0] r_destino;
  logic              r_valido;
  logic              w_llegada;
  logic              w_timeout;

`ifdef DESPACHO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CICLOS + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_excluir;

  // Counts cycles spent waiting for ack; restarts on every new assignment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_excluir <= 1'b0;
    end else begin
      r_cnt     <= (r_estado == ASIGNANDO && w_estado_sig == ASIGNANDO) ? r_cnt + 1'b1 : '0;
      r_excluir <= w_timeout;
    end
  end

  assign o_elegible = (r_estado == LIBRE) && (i_direccion == DIR_PARADO) && !r_excluir;
`else
  assign o_elegible = (r_estado == LIBRE) && (i_direccion == DIR_PARADO);
`endif

  // Next-state logic; arrival and timeout are single-cycle strobes to the top.
  always_comb begin
    w_estado_sig = r_estado;
    w_llegada    = 1'b0;
    w_timeout    = 1'b0;
    case (r_estado)
      LIBRE: begin
        if (i_asignar) w_estado_sig = ASIGNANDO;
      end
      ASIGNANDO: begin
        if (i_ack) begin
          w_estado_sig = EN_VIAJE;
        end
`ifdef DESPACHO_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CICLOS - 1)) begin
          w_timeout    = 1'b1;
          w_estado_sig = LIBRE;
        end
`endif
      end
      EN_VIAJE: begin
        if (i_piso == r_destino && i_puertas) begin
          w_llegada    = 1'b1;
          w_estado_sig = LIBRE;
        end
      end
      default: w_estado_sig = LIBRE;
    endcase
  end

  // State, destino and valid registers; destino only loads from LIBRE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado  <= LIBRE;
      r_destino <= '0;
      r_valido  <= 1'b0;
    end else begin
      r_estado <= w_estado_sig;
      r_valido <= (w_estado_sig == ASIGNANDO);
      if (r_estado == LIBRE && i_asignar) r_destino <= i_destino;
    end
  end

  assign o_destino = r_destino;
  assign o_valido  = r_valido;
  assign o_llegada = w_llegada;
  assign o_timeout = w_timeout;
  assign o_estado  = r_estado;

endmodule

// File: rtl/despachador_llamadas.sv
// Call dispatcher for two elevators: latches call-button rising edges,
// picks the lowest unassigned pending floor and hands it to the closest
// idle elevator (tie -> elevator 1), at most one assignment per cycle.
// Optional ack timeout is enabled with the macro DESPACHO_TIMEOUT_EN.
module despachador_llamadas
  import despacho_pkg::*;
#(
  parameter int N_PISOS        = N_PISOS_DEF,
  parameter int PISO_W         = PISO_W_DEF,
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PISOS-1:0] llamada,
  input  logic [PISO_W-1:0]  piso_asc_1,
  input  logic [1:0]         direccion_asc_1,
  input  logic               puertas_abiertas_asc_1,
  input  logic               destino_ack_asc_1,
  input  logic [PISO_W-1:0]  piso_asc_2,
  input  logic [1:0]         direccion_asc_2,
  input  logic               puertas_abiertas_asc_2,
  input  logic               destino_ack_asc_2,
  output logic [PISO_W-1:0]  destino_asc_1,
  output logic               destino_valido_asc_1,
  output logic [PISO_W-1:0]  destino_asc_2,
  output logic               destino_valido_asc_2,
  output logic [N_PISOS-1:0] llamadas_pendientes
);

  logic [N_PISOS-1:0] r_llamada_prev;
  logic [N_PISOS-1:0] r_pendiente;
  logic [N_PISOS-1:0] r_asignada;

  logic [N_PISOS-1:0] w_flanco;
  logic [N_PISOS-1:0] w_libres;
  logic [N_PISOS-1:0] w_limpiar;
  logic [N_PISOS-1:0] w_liberar;
  logic [N_PISOS-1:0] w_marcar;
  logic [PISO_W-1:0]  w_cand;
  logic               w_hay_cand;
  logic [PISO_W-1:0]  w_dist_1;
  logic [PISO_W-1:0]  w_dist_2;
  logic               w_eleg_1, w_eleg_2;
  logic               w_asig_1, w_asig_2;
  logic               w_llegada_1, w_llegada_2;
  logic               w_timeout_1, w_timeout_2;
  logic [1:0]         w_estado_1, w_estado_2;

  assign w_flanco = llamada & ~r_llamada_prev;
  assign w_libres = r_pendiente & ~r_asignada;

  // Lowest-index pending floor that no elevator is serving yet.
  always_comb begin
    w_cand     = '0;
    w_hay_cand = 1'b0;
    for (int i = N_PISOS - 1; i >= 0; i--) begin
      if (w_libres[i]) begin
        w_hay_cand = 1'b1;
        w_cand     = PISO_W'(i);
      end
    end
  end

  // Distance arbitration between eligible elevators; ties favour elevator 1.
  always_comb begin
    w_dist_1 = (piso_asc_1 > w_cand) ? piso_asc_1 - w_cand : w_cand - piso_asc_1;
    w_dist_2 = (piso_asc_2 > w_cand) ? piso_asc_2 - w_cand : w_cand - piso_asc_2;
    w_asig_1 = w_hay_cand && w_eleg_1 && (!w_eleg_2 || (w_dist_1 <= w_dist_2));
    w_asig_2 = w_hay_cand && w_eleg_2 && !w_asig_1;
  end

  // Floor masks to set/clear this cycle from assignment, arrival and timeout.
  always_comb begin
    w_marcar  = '0;
    w_limpiar = '0;
    w_liberar = '0;
    if (w_asig_1 || w_asig_2) w_marcar[w_cand] = 1'b1;
    if (w_llegada_1) w_limpiar[destino_asc_1] = 1'b1;
    if (w_llegada_2) w_limpiar[destino_asc_2] = 1'b1;
    if (w_timeout_1) w_liberar[destino_asc_1] = 1'b1;
    if (w_timeout_2) w_liberar[destino_asc_2] = 1'b1;
  end

  // Call capture and masks; a new press wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_llamada_prev <= '0;
      r_pendiente    <= '0;
      r_asignada     <= '0;
    end else begin
      r_llamada_prev <= llamada;
      r_pendiente    <= (r_pendiente & ~w_limpiar) | w_flanco;
      r_asignada     <= (r_asignada & ~w_limpiar & ~w_liberar) | w_marcar;
    end
  end

  assign llamadas_pendientes = r_pendiente;

  asignador_asc #(
    .PISO_W         (PISO_W),
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
  ) u_asc_1 (
    .clk         (clk),
    .rst         (rst),
    .i_asignar   (w_asig_1),
    .i_destino   (w_cand),
    .i_piso      (piso_asc_1),
    .i_direccion (direccion_asc_1),
    .i_puertas   (puertas_abiertas_asc_1),
    .i_ack       (destino_ack_asc_1),
    .o_destino   (destino_asc_1),
    .o_valido    (destino_valido_asc_1),
    .o_elegible  (w_eleg_1),
    .o_llegada   (w_llegada_1),
    .o_timeout   (w_timeout_1),
    .o_estado    (w_estado_1)
  );

  asignador_asc #(
    .PISO_W         (PISO_W),
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
  ) u_asc_2 (
    .clk         (clk),
    .rst         (rst),
    .i_asignar   (w_asig_2),
    .i_destino   (w_cand),
    .i_piso      (piso_asc_2),
    .i_direccion (direccion_asc_2),
    .i_puertas   (puertas_abiertas_asc_2),
    .i_ack       (destino_ack_asc_2),
    .o_destino   (destino_asc_2),
    .o_valido    (destino_valido_asc_2),
    .o_elegible  (w_eleg_2),
    .o_llegada   (w_llegada_2),
    .o_timeout   (w_timeout_2),
    .o_estado    (w_estado_2)
  );

endmodule

// File: tb/tb_despachador_llamadas.sv
// Directed bench for despachador_llamadas. Inputs change 1 ns after the
// rising edge and outputs are sampled at that same point.
module tb_despachador_llamadas;
  import despacho_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] llamada;
  logic [1:0] piso_asc_1, piso_asc_2;
  logic [1:0] direccion_asc_1, direccion_asc_2;
  logic       puertas_abiertas_asc_1, puertas_abiertas_asc_2;
  logic       destino_ack_asc_1, destino_ack_asc_2;
  logic [1:0] destino_asc_1, destino_asc_2;
  logic       destino_valido_asc_1, destino_valido_asc_2;
  logic [3:0] llamadas_pendientes;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  despachador_llamadas #(
    .N_PISOS(4), .PISO_W(2), .TIMEOUT_CICLOS(8)
  ) dut (
    .clk(clk), .rst(rst), .llamada(llamada),
    .piso_asc_1(piso_asc_1), .direccion_asc_1(direccion_asc_1),
    .puertas_abiertas_asc_1(puertas_abiertas_asc_1), .destino_ack_asc_1(destino_ack_asc_1),
    .piso_asc_2(piso_asc_2), .direccion_asc_2(direccion_asc_2),
    .puertas_abiertas_asc_2(puertas_abiertas_asc_2), .destino_ack_asc_2(destino_ack_asc_2),
    .destino_asc_1(destino_asc_1), .destino_valido_asc_1(destino_valido_asc_1),
    .destino_asc_2(destino_asc_2), .destino_valido_asc_2(destino_valido_asc_2),
    .llamadas_pendientes(llamadas_pendientes)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; llamada = '0;
    piso_asc_1 = 2'd0; piso_asc_2 = 2'd3;
    direccion_asc_1 = DIR_PARADO; direccion_asc_2 = DIR_PARADO;
    puertas_abiertas_asc_1 = 0; puertas_abiertas_asc_2 = 0;
    destino_ack_asc_1 = 0; destino_ack_asc_2 = 0;
    tick(2);
    n_checks++; if (llamadas_pendientes !== 4'b0000) begin n_errors++; $display("FAIL reset_pend: got %b want 0000", llamadas_pendientes); end
    n_checks++; if (destino_valido_asc_1 !== 1'b0) begin n_errors++; $display("FAIL reset_valid1: got %b want 0", destino_valido_asc_1); end
    n_checks++; if (destino_valido_asc_2 !== 1'b0) begin n_errors++; $display("FAIL reset_valid2: got %b want 0", destino_valido_asc_2); end
    n_checks++; if (destino_asc_1 !== 2'd0) begin n_errors++; $display("FAIL reset_dest1: got %0d want 0", destino_asc_1); end
    n_checks++; if (destino_asc_2 !== 2'd0) begin n_errors++; $display("FAIL reset_dest2: got %0d want 0", destino_asc_2); end
    rst = 1'b0;
    tick(1);
  endtask

  // asc_1 at 0, asc_2 at 3, call floor 2 -> asc_2 (distance 1 vs 2).
  task automatic test_distancia;
    llamada = 4'b0100;
    tick(1);
    n_checks++; if (llamadas_pendientes !== 4'b0100) begin n_errors++; $display("FAIL dist_pend: got %b want 0100", llamadas_pendientes); end
    n_checks++; if (destino_valido_asc_2 !== 1'b0) begin n_errors++; $display("FAIL dist_valid2_early: got %b want 0", destino_valido_asc_2); end
    tick(1);
    n_checks++; if (destino_valido_asc_2 !== 1'b1) begin n_errors++; $display("FAIL dist_valid2: got %b want 1", destino_valido_asc_2); end
    n_checks++; if (destino_asc_2 !== 2'd2) begin n_errors++; $display("FAIL dist_dest2: got %0d want 2", destino_asc_2); end
    n_checks++; if (destino_valido_asc_1 !== 1'b0) begin n_errors++; $display("FAIL dist_valid1: got %b want 0", destino_valido_asc_1); end
    destino_ack_asc_2 = 1'b1;
    tick(1);
    destino_ack_asc_2 = 1'b0;
    n_checks++; if (destino_valido_asc_2 !== 1'b0) begin n_errors++; $display("FAIL dist_valid2_after_ack: got %b want 0", destino_valido_asc_2); end
    piso_asc_2 = 2'd2; puertas_abiertas_asc_2 = 1'b1;
    tick(1);
    n_checks++; if (llamadas_pendientes !== 4'b0000) begin n_errors++; $display("FAIL dist_clear: got %b want 0000", llamadas_pendientes); end
    puertas_abiertas_asc_2 = 1'b0; llamada = '0;
    tick(1);
  endtask

  // Both at floor 1, call floor 2: tie -> asc_1; hold without ack, then arrival.
  task automatic test_empate_y_llegada;
    piso_asc_1 = 2'd1; piso_asc_2 = 2'd1;
    llamada = 4'b0100;
    tick(2);
    n_checks++; if (destino_valido_asc_1 !== 1'b1 || destino_asc_1 !== 2'd2) begin n_errors++; $display("FAIL tie_asc1: got v=%b d=%0d want v=1 d=2", destino_valido_asc_1, destino_asc_1); end
    n_checks++; if (destino_valido_asc_2 !== 1'b0) begin n_errors++; $display("FAIL tie_valid2: got %b want 0", destino_valido_asc_2); end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_checks++; if (destino_valido_asc_1 !== 1'b1 || destino_asc_1 !== 2'd2) begin n_errors++; $display("FAIL hold_stable[%0d]: got v=%b d=%0d want v=1 d=2", i, destino_valido_asc_1, destino_asc_1); end
    end
    destino_ack_asc_1 = 1'b1;
    tick(1);
    destino_ack_asc_1 = 1'b0;
    n_checks++; if (destino_valido_asc_1 !== 1'b0) begin n_errors++; $display("FAIL ack_drop: got %b want 0", destino_valido_asc_1); end
    piso_asc_1 = 2'd2;
    tick(2);
    n_checks++; if (llamadas_pendientes !== 4'b0100) begin n_errors++; $display("FAIL no_doors_pend: got %b want 0100", llamadas_pendientes); end
    puertas_abiertas_asc_1 = 1'b1;
    tick(1);
    n_checks++; if (llamadas_pendientes !== 4'b0000) begin n_errors++; $display("FAIL arrival_clear: got %b want 0000", llamadas_pendientes); end
    n_checks++; if (dut.u_asc_1.o_estado !== LIBRE) begin n_errors++; $display("FAIL arrival_libre: got %0d want %0d", dut.u_asc_1.o_estado, LIBRE); end
    puertas_abiertas_asc_1 = 1'b0; llamada = '0;
    tick(1);
  endtask

  // Moving asc_1 is not eligible even when it is closer.
  task automatic test_direccion;
    piso_asc_1 = 2'd0; direccion_asc_1 = DIR_SUBE; piso_asc_2 = 2'd3;
    llamada = 4'b0001;
    tick(2);
    n_checks++; if (destino_valido_asc_2 !== 1'b1 || destino_asc_2 !== 2'd0) begin n_errors++; $display("FAIL dir_asc2: got v=%b d=%0d want v=1 d=0", destino_valido_asc_2, destino_asc_2); end
    n_checks++; if (destino_valido_asc_1 !== 1'b0) begin n_errors++; $display("FAIL dir_valid1: got %b want 0", destino_valido_asc_1); end
    destino_ack_asc_2 = 1'b1;
    tick(1);
    destino_ack_asc_2 = 1'b0; piso_asc_2 = 2'd0; puertas_abiertas_asc_2 = 1'b1;
    tick(1);
    n_checks++; if (llamadas_pendientes !== 4'b0000) begin n_errors++; $display("FAIL dir_clear: got %b want 0000", llamadas_pendientes); end
    puertas_abiertas_asc_2 = 1'b0; direccion_asc_1 = DIR_PARADO; llamada = '0;
    piso_asc_2 = 2'd3;
    tick(1);
  endtask

  // Idle asc_1 standing at floor 0 with doors open and ack tied high.
  task automatic test_llegada_inmediata;
    piso_asc_1 = 2'd0; puertas_abiertas_asc_1 = 1'b1; destino_ack_asc_1 = 1'b1;
    llamada = 4'b0001;
    tick(1);
    n_checks++; if (llamadas_pendientes !== 4'b0001) begin n_errors++; $display("FAIL inm_c1: got %b want 0001", llamadas_pendientes); end
    tick(1);
    n_checks++; if (destino_valido_asc_1 !== 1'b1 || llamadas_pendientes !== 4'b0001) begin n_errors++; $display("FAIL inm_c2: got v=%b p=%b want v=1 p=0001", destino_valido_asc_1, llamadas_pendientes); end
    tick(1);
    n_checks++; if (destino_valido_asc_1 !== 1'b0 || llamadas_pendientes !== 4'b0001) begin n_errors++; $display("FAIL inm_c3: got v=%b p=%b want v=0 p=0001", destino_valido_asc_1, llamadas_pendientes); end
    tick(1);
    n_checks++; if (llamadas_pendientes !== 4'b0000) begin n_errors++; $display("FAIL inm_clear: got %b want 0000", llamadas_pendientes); end
    puertas_abiertas_asc_1 = 1'b0; destino_ack_asc_1 = 1'b0; llamada = '0;
    tick(1);
  endtask

`ifdef DESPACHO_TIMEOUT_EN
  // No ack on asc_1: valid for 8 cycles, then the call moves to asc_2.
  task automatic test_timeout;
    llamada = 4'b0001;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (destino_valido_asc_1 !== 1'b1) begin n_errors++; $display("FAIL to_valid[%0d]: got %b want 1", i, destino_valido_asc_1); end
      tick(1);
    end
    n_checks++; if (destino_valido_asc_1 !== 1'b0) begin n_errors++; $display("FAIL to_drop: got %b want 0", destino_valido_asc_1); end
    n_checks++; if (llamadas_pendientes !== 4'b0001) begin n_errors++; $display("FAIL to_pend: got %b want 0001", llamadas_pendientes); end
    tick(1);
    n_checks++; if (destino_valido_asc_2 !== 1'b1 || destino_asc_2 !== 2'd0) begin n_errors++; $display("FAIL to_reassign: got v=%b d=%0d want v=1 d=0", destino_valido_asc_2, destino_asc_2); end
    n_checks++; if (destino_valido_asc_1 !== 1'b0) begin n_errors++; $display("FAIL to_excl: got %b want 0", destino_valido_asc_1); end
    destino_ack_asc_2 = 1'b1;
    tick(1);
    destino_ack_asc_2 = 1'b0; piso_asc_2 = 2'd0; puertas_abiertas_asc_2 = 1'b1;
    tick(1);
    n_checks++; if (llamadas_pendientes !== 4'b0000) begin n_errors++; $display("FAIL to_clear: got %b want 0000", llamadas_pendientes); end
    puertas_abiertas_asc_2 = 1'b0; llamada = '0;
    tick(1);
  endtask
`else
  // No ack on asc_1: valid stays up well past any timeout window.
  task automatic test_sin_timeout;
    llamada = 4'b0001;
    tick(14);
    n_checks++; if (destino_valido_asc_1 !== 1'b1 || destino_asc_1 !== 2'd0) begin n_errors++; $display("FAIL nto_hold: got v=%b d=%0d want v=1 d=0", destino_valido_asc_1, destino_asc_1); end
    n_checks++; if (destino_valido_asc_2 !== 1'b0) begin n_errors++; $display("FAIL nto_valid2: got %b want 0", destino_valido_asc_2); end
    destino_ack_asc_1 = 1'b1;
    tick(1);
    destino_ack_asc_1 = 1'b0; puertas_abiertas_asc_1 = 1'b1;
    tick(1);
    n_checks++; if (llamadas_pendientes !== 4'b0000) begin n_errors++; $display("FAIL nto_clear: got %b want 0000", llamadas_pendientes); end
    puertas_abiertas_asc_1 = 1'b0; llamada = '0;
    tick(1);
  endtask
`endif

  // Two calls at once: one assignment per cycle, then async reset mid-handshake.
  task automatic test_back_to_back;
    piso_asc_1 = 2'd0; piso_asc_2 = 2'd0;
    llamada = 4'b1010;
    tick(1);
    n_checks++; if (llamadas_pendientes !== 4'b1010 || destino_valido_asc_1 !== 1'b0 || destino_valido_asc_2 !== 1'b0) begin n_errors++; $display("FAIL b2b_c1: got p=%b v1=%b v2=%b want p=1010 v1=0 v2=0", llamadas_pendientes, destino_valido_asc_1, destino_valido_asc_2); end
    tick(1);
    n_checks++; if (destino_valido_asc_1 !== 1'b1 || destino_asc_1 !== 2'd1 || destino_valido_asc_2 !== 1'b0) begin n_errors++; $display("FAIL b2b_c2: got v1=%b d1=%0d v2=%b want v1=1 d1=1 v2=0", destino_valido_asc_1, destino_asc_1, destino_valido_asc_2); end
    tick(1);
    n_checks++; if (destino_valido_asc_2 !== 1'b1 || destino_asc_2 !== 2'd3 || destino_valido_asc_1 !== 1'b1) begin n_errors++; $display("FAIL b2b_c3: got v2=%b d2=%0d v1=%b want v2=1 d2=3 v1=1", destino_valido_asc_2, destino_asc_2, destino_valido_asc_1); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (destino_valido_asc_1 !== 1'b0 || destino_valido_asc_2 !== 1'b0 || llamadas_pendientes !== 4'b0000 || destino_asc_1 !== 2'd0 || destino_asc_2 !== 2'd0) begin n_errors++; $display("FAIL async_rst: got v1=%b v2=%b p=%b d1=%0d d2=%0d want all 0", destino_valido_asc_1, destino_valido_asc_2, llamadas_pendientes, destino_asc_1, destino_asc_2); end
    llamada = '0;
    #1;
    rst = 1'b0;
    tick(2);
    n_checks++; if (llamadas_pendientes !== 4'b0000 || destino_valido_asc_1 !== 1'b0) begin n_errors++; $display("FAIL post_rst: got p=%b v1=%b want p=0000 v1=0", llamadas_pendientes, destino_valido_asc_1); end
  endtask

  initial begin
    test_reset;
    test_distancia;
    test_empate_y_llegada;
    test_direccion;
    test_llegada_inmediata;
`ifdef DESPACHO_TIMEOUT_EN
    test_timeout;
`else
    test_sin_timeout;
`endif
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
